// File: rtl/rx_block_sync.sv
// 66-bit block synchronizer: sync-header lock FSM with gearbox slip, 1-cycle datapath.
// Optional hi-BER monitor enabled by defining RX_BLOCK_SYNC_HIBER_EN.
module rx_block_sync #(
    parameter int LOCK_CNT  = 64,
    parameter int WIN_CNT   = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 4,
    parameter int HBER_WIN  = 20000,
    parameter int HBER_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [65:0] data_in,
    input  logic        data_in_valid,
    output logic [65:0] data_out,
    output logic        data_out_valid,
    output logic        block_lock,
    output logic        slip,
    output logic        hi_ber
);

    localparam int GOOD_W = $clog2(LOCK_CNT) + 1;
    localparam int WIN_W  = $clog2(WIN_CNT) + 1;
    localparam int BAD_W  = $clog2(BAD_MAX) + 1;
    localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

    localparam logic [GOOD_W-1:0] GOOD_TERM = GOOD_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]  WIN_TERM  = WIN_W'(WIN_CNT);
    localparam logic [BAD_W-1:0]  BAD_TERM  = BAD_W'(BAD_MAX);
    localparam logic [WAIT_W-1:0] WAIT_TERM = WAIT_W'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t              state_q;
    logic [65:0]         data_q;
    logic                dvld_q;
    logic                lock_q;
    logic                slip_q;
    logic [GOOD_W-1:0]   good_q;
    logic [WIN_W-1:0]    win_q;
    logic [BAD_W-1:0]    bad_q;
    logic [WAIT_W-1:0]   wait_q;

    logic                hdr_ok_d;
    logic [GOOD_W-1:0]   good_d;
    logic [WIN_W-1:0]    win_d;
    logic [BAD_W-1:0]    bad_d;
    logic [WAIT_W-1:0]   wait_d;

    // Saturating increments; the FSM decides whether they are taken.
    always_comb begin
        hdr_ok_d = data_in[1] ^ data_in[0];
        good_d   = (good_q == GOOD_TERM) ? good_q : good_q + GOOD_W'(1);
        win_d    = (win_q == WIN_TERM) ? win_q : win_q + WIN_W'(1);
        wait_d   = (wait_q == WAIT_TERM) ? wait_q : wait_q + WAIT_W'(1);
        bad_d    = bad_q;
        if (!hdr_ok_d && (bad_q != BAD_TERM)) begin
            bad_d = bad_q + BAD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HUNT;
            data_q  <= '0;
            dvld_q  <= 1'b0;
            lock_q  <= 1'b0;
            slip_q  <= 1'b0;
            good_q  <= '0;
            win_q   <= '0;
            bad_q   <= '0;
            wait_q  <= '0;
        end else begin
            data_q <= data_in;
            dvld_q <= data_in_valid;
            slip_q <= 1'b0;
            if (data_in_valid) begin
                case (state_q)
                    ST_HUNT: begin
                        if (!hdr_ok_d) begin
                            slip_q  <= 1'b1;
                            good_q  <= '0;
                            wait_q  <= '0;
                            state_q <= ST_SLIP_WAIT;
                        end else if (good_d == GOOD_TERM) begin
                            lock_q  <= 1'b1;
                            good_q  <= good_d;
                            win_q   <= '0;
                            bad_q   <= '0;
                            state_q <= ST_LOCKED;
                        end else begin
                            good_q <= good_d;
                        end
                    end
                    ST_SLIP_WAIT: begin
                        if (wait_d == WAIT_TERM) begin
                            wait_q  <= '0;
                            good_q  <= '0;
                            state_q <= ST_HUNT;
                        end else begin
                            wait_q <= wait_d;
                        end
                    end
                    ST_LOCKED: begin
                        // Loss of lock wins over the window rollover on the same block.
                        if (bad_d == BAD_TERM) begin
                            lock_q  <= 1'b0;
                            slip_q  <= 1'b1;
                            good_q  <= '0;
                            win_q   <= '0;
                            bad_q   <= '0;
                            wait_q  <= '0;
                            state_q <= ST_SLIP_WAIT;
                        end else if (win_d == WIN_TERM) begin
                            win_q <= '0;
                            bad_q <= '0;
                        end else begin
                            win_q <= win_d;
                            bad_q <= bad_d;
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = dvld_q;
    assign block_lock     = lock_q;
    assign slip           = slip_q;

`ifdef RX_BLOCK_SYNC_HIBER_EN
    localparam int TMR_W = $clog2(HBER_WIN) + 1;
    localparam int BER_W = $clog2(HBER_MAX) + 1;
    localparam logic [TMR_W-1:0] TMR_TERM = TMR_W'(HBER_WIN - 1);
    localparam logic [BER_W-1:0] BER_TERM = BER_W'(HBER_MAX);

    logic [TMR_W-1:0] tmr_q;
    logic [BER_W-1:0] ber_q;
    logic             hiber_q;
    logic             ber_hit_d;

    assign ber_hit_d = data_in_valid & ~hdr_ok_d;

    // A bad header on the expiry cycle seeds the next window's count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q   <= '0;
            ber_q   <= '0;
            hiber_q <= 1'b0;
        end else if (tmr_q == TMR_TERM) begin
            tmr_q   <= '0;
            hiber_q <= (ber_q >= BER_TERM);
            ber_q   <= ber_hit_d ? BER_W'(1) : '0;
        end else begin
            tmr_q <= tmr_q + TMR_W'(1);
            if (ber_hit_d && (ber_q != BER_TERM)) begin
                ber_q <= ber_q + BER_W'(1);
            end
            if (ber_q == BER_TERM) begin
                hiber_q <= 1'b1;
            end
        end
    end

    assign hi_ber = hiber_q;
`else
    // hi_ber stays low; HBER_* are still accepted so both builds share one instantiation.
    localparam bit HBER_CFG_OK = (HBER_WIN > 1) && (HBER_MAX > 0);
    assign hi_ber = 1'b0 & HBER_CFG_OK;
`endif

endmodule

// File: tb/tb_rx_block_sync.sv
// Directed bench for rx_block_sync: lock acquisition, slip/ignore, window and loss-of-lock,
// valid gaps, async reset, and hi-BER when RX_BLOCK_SYNC_HIBER_EN is defined.
module tb_rx_block_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [65:0] data_in;
    logic        data_in_valid;
    logic [65:0] data_out;
    logic        data_out_valid;
    logic        block_lock;
    logic        slip;
    logic        hi_ber;

    int checks   = 0;
    int failures = 0;
    int seq      = 0;

    always #5 clk = ~clk;

    rx_block_sync #(.HBER_WIN(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .block_lock     (block_lock),
        .slip           (slip),
        .hi_ber         (hi_ber)
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] h, input logic v);
        seq++;
        data_in       = {32'hC0DE_0000 | 32'(seq), 32'($urandom()), h};
        data_in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input logic [1:0] h, input logic v, input logic exp_lock,
                       input logic exp_slip, input string tag);
        logic [65:0] sent;
        drive(h, v);
        sent = data_in;
        chk({tag, "_data"}, data_out, sent);
        chk({tag, "_dvld"}, 66'(data_out_valid), 66'(v));
        chk({tag, "_lock"}, 66'(block_lock), 66'(exp_lock));
        chk({tag, "_slip"}, 66'(slip), 66'(exp_slip));
`ifndef RX_BLOCK_SYNC_HIBER_EN
        chk({tag, "_hiber"}, 66'(hi_ber), 66'(0));
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, data_out, 66'(0));
        chk({tag, "_dvld"}, 66'(data_out_valid), 66'(0));
        chk({tag, "_lock"}, 66'(block_lock), 66'(0));
        chk({tag, "_slip"}, 66'(slip), 66'(0));
        chk({tag, "_hiber"}, 66'(hi_ber), 66'(0));
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b1;

        // Acquire: lock visible right after the 64th good header.
        for (int i = 1; i <= 63; i++) blk(2'b01, 1'b1, 1'b0, 1'b0, "acq");
        blk(2'b01, 1'b1, 1'b1, 1'b0, "acq64");

        // 15 bad headers spread over one window: lock holds.
        for (int i = 0; i < 64; i++)
            blk(((i % 4 == 0) && (i < 60)) ? 2'b00 : 2'b01, 1'b1, 1'b1, 1'b0, "win15");

        // Next window: 15 bad early, 16th on block 64 -> loss beats rollover.
        for (int i = 0; i < 15; i++) blk(2'b00, 1'b1, 1'b1, 1'b0, "win2_bad");
        for (int i = 15; i < 63; i++) blk(2'b01, 1'b1, 1'b1, 1'b0, "win2_good");
        blk(2'b00, 1'b1, 1'b0, 1'b1, "loss");

        // Slip wait: 4 blocks ignored even with invalid headers, no re-slip.
        for (int i = 0; i < 4; i++) blk(2'b11, 1'b1, 1'b0, 1'b0, "swait1");

        // Hunt: 10 good, then 2'b11 -> single slip, 4 ignored, then 64 fresh goods.
        for (int i = 0; i < 10; i++) blk(2'b10, 1'b1, 1'b0, 1'b0, "hunt10");
        blk(2'b11, 1'b1, 1'b0, 1'b1, "hunt_slip");
        for (int i = 0; i < 4; i++) blk(2'b11, 1'b1, 1'b0, 1'b0, "swait2");
        for (int i = 1; i <= 63; i++) blk(2'b01, 1'b1, 1'b0, 1'b0, "reacq");
        blk(2'b01, 1'b1, 1'b1, 1'b0, "reacq64");

        // Asynchronous reset while locked: outputs clear before the next edge.
        rst = 1'b0;
        #2;
        chk_zero("rst_locked");
        release_rst();

        // Mid-hunt reset also clears the good count.
        for (int i = 0; i < 20; i++) blk(2'b01, 1'b1, 1'b0, 1'b0, "hunt20");
        rst = 1'b0;
        #2;
        chk_zero("rst_hunt");
        release_rst();

        // Valid toggling: gap cycles carry bad headers that must not be evaluated.
        for (int k = 1; k <= 64; k++) begin
            blk(2'b01, 1'b1, (k == 64), 1'b0, "tog_v");
            blk(2'b00, 1'b0, (k == 64), 1'b0, "tog_gap");
        end

`ifdef RX_BLOCK_SYNC_HIBER_EN
        rst = 1'b0;
        #2;
        chk_zero("rst_hiber");
        release_rst();
        for (int i = 0; i < 16; i++) drive(2'b00, 1'b1);
        chk("hiber_early", 66'(hi_ber), 66'(0));
        repeat (2) drive(2'b01, 1'b1);
        chk("hiber_set", 66'(hi_ber), 66'(1));
        repeat (132) drive(2'b01, 1'b1);
        chk("hiber_hold", 66'(hi_ber), 66'(1));
        repeat (100) drive(2'b01, 1'b1);
        chk("hiber_clear", 66'(hi_ber), 66'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
